ps2_receiver: RTL and testbench
===============================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000, max wr_clk cycles between ps2_clk falling edges inside a frame (100 us at 50 MHz).
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 wr_clk  input  1  system clock; all state and outputs clocked on its rising edge.
REQ-004 ps2_clk  input  1  raw PS/2 clock from device, asynchronous to wr_clk.
REQ-005 ps2_data  input  1  raw PS/2 data from device, asynchronous to wr_clk.
REQ-006 wr_data  output  8  last correctly received scan-code byte; feeds keyboard buffer write data.
REQ-007 we  output  1  one-cycle write strobe, valid with wr_data; feeds keyboard buffer write enable.
REQ-008 frame_err  output  1  one-cycle pulse on bad stop bit or inter-edge timeout.
REQ-009 parity_err  output  1  one-cycle pulse on odd-parity failure (only when parity check compiled in).
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synchronized-sample 1 then 0 on consecutive cycles.
REQ-012 Frame format: start(0), 8 data bits LSB first, odd parity, stop(1); each bit sampled from synchronized ps2_data on the cycle its falling edge is detected.
REQ-013 States: IDLE, DATA, PARITY, STOP; IDLE->DATA on edge with sampled 0; DATA->PARITY after 8th data edge (3-bit counter); PARITY->STOP on next edge; STOP->IDLE on next edge.
REQ-014 Edge in IDLE sampling 1 (false start) SHALL be ignored: stay IDLE, no error pulse.
REQ-015 On good frame, wr_data SHALL update and we SHALL pulse high for exactly one cycle, registered on the cycle after the stop-bit edge is detected (3 wr_clk edges after stop-bit fall at pin).
REQ-016 Stop bit sampled 0 SHALL pulse frame_err one cycle, suppress we, leave wr_data unchanged, return to IDLE.
REQ-017 A 13-bit timeout counter SHALL clear on every detected edge and count while not IDLE; reaching TIMEOUT_CYCLES SHALL pulse frame_err, discard partial byte, force IDLE.
REQ-018 wr_data SHALL hold its value between good frames; we, frame_err, parity_err never asserted together.
REQ-019 Back-to-back frames with no idle gap SHALL each be received; we pulses never merge.

Reset
REQ-020 Reset SHALL force IDLE, clear shift register, bit counter, timeout counter, synchronizers to 1.
REQ-021 Reset values: wr_data=0x00, we=0, frame_err=0, parity_err=0, busy=0.
REQ-022 Reset mid-frame SHALL abort the frame with no we or error pulse; next start bit after release begins a new frame.

Configuration
REQ-023 Macro PS2_RX_PARITY_CHECK_EN defined: parity failure pulses parity_err one cycle at stop-bit edge, suppresses we, wr_data unchanged.
REQ-024 Macro PS2_RX_PARITY_CHECK_EN undefined: parity bit sampled and ignored; parity_err tied 0; good stop bit always yields we.

Verification
REQ-025 Send 0x1C, parity 0, stop 1, 12.5 kHz ps2_clk, wr_clk 50 MHz -> wr_data=0x1C, we high exactly one cycle, no errors, busy back to 0.
REQ-026 Send 0xF0 then 0x1C back-to-back -> two separate we pulses, wr_data 0xF0 then 0x1C.
REQ-027 Send 0x1C with parity 1 -> with PS2_RX_PARITY_CHECK_EN: parity_err pulse, no we, wr_data unchanged; without: we with 0x1C.
REQ-028 Send 0x1C with stop bit 0 -> frame_err one-cycle pulse, no we, state IDLE.
REQ-029 Send start plus 4 data bits, hold ps2_clk high 6000 cycles -> frame_err pulse at cycle 5000, IDLE; following 0xF0 frame received correctly.
REQ-030 Assert reset after 5th data bit of 0x1C, release, send 0xF0 -> no output for aborted frame, all outputs 0 during reset, then we with 0xF0.

Source files
------------

// File: rtl/ps2_receiver.sv
// ps2_receiver
// Receives PS/2 device-to-host frames and hands each good scan-code byte to the
// keyboard buffer as a one-cycle write.
//
// Frame on the wire: start(0), 8 data bits LSB first, odd parity, stop(1).
// Each bit is taken from the synchronized data line on the wr_clk cycle where a
// falling edge of the synchronized PS/2 clock is seen.
//
// Parameters
//   TIMEOUT_CYCLES  max wr_clk cycles allowed between PS/2 clock falls inside a
//                   frame before the frame is abandoned (5000 = 100 us @ 50 MHz)
//
// Ports
//   reset       in   asynchronous, active-high reset
//   wr_clk      in   system clock, everything updates on its rising edge
//   ps2_clk     in   raw PS/2 clock from the device (asynchronous)
//   ps2_data    in   raw PS/2 data from the device (asynchronous)
//   wr_data     out  [7:0] last correctly received byte
//   we          out  one-cycle write strobe, valid together with wr_data
//   frame_err   out  one-cycle pulse on bad stop bit or inter-edge timeout
//   parity_err  out  one-cycle pulse on odd-parity failure
//   busy        out  high whenever a frame is in progress
//
// Build option
//   PS2_RX_PARITY_CHECK_EN  when defined, frames with bad parity are rejected
//                           and flagged on parity_err; when undefined the
//                           parity bit is ignored and parity_err stays 0.
`timescale 1ns/1ps

module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       reset,
  input  logic       wr_clk,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] wr_data,
  output logic       we,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [12:0] TIMEOUT_LIMIT = 13'(TIMEOUT_CYCLES);

  state_t      state;
  logic        ps2_clk_s1;
  logic        ps2_clk_s2;
  logic        ps2_clk_prev;
  logic        ps2_data_s1;
  logic        ps2_data_s2;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic [12:0] timeout_cnt;
  logic        fall_edge;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic        parity_bit;
`endif

  // Two-flop synchronizers for both PS/2 lines plus one extra stage on the
  // clock so a falling edge can be seen as 1 followed by 0. They reset to 1,
  // the idle level of an open-collector PS/2 bus.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      ps2_clk_s1   <= 1'b1;
      ps2_clk_s2   <= 1'b1;
      ps2_clk_prev <= 1'b1;
      ps2_data_s1  <= 1'b1;
      ps2_data_s2  <= 1'b1;
    end else begin
      ps2_clk_s1   <= ps2_clk;
      ps2_clk_s2   <= ps2_clk_s1;
      ps2_clk_prev <= ps2_clk_s2;
      ps2_data_s1  <= ps2_data;
      ps2_data_s2  <= ps2_data_s1;
    end
  end

  assign fall_edge = ps2_clk_prev & ~ps2_clk_s2;
  assign busy      = (state != IDLE);

  // Frame FSM. The strobes default low every cycle so each one is a single
  // cycle pulse; the stop-bit cycle decides which one (if any) fires, which
  // keeps we, frame_err and parity_err mutually exclusive. The inter-edge
  // timeout takes priority over everything else and drops the partial byte.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= 8'h00;
      bit_cnt     <= 3'd0;
      timeout_cnt <= 13'd0;
      wr_data     <= 8'h00;
      we          <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_err  <= 1'b0;
      parity_bit  <= 1'b0;
`endif
    end else begin
      we        <= 1'b0;
      frame_err <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      if (state != IDLE && !fall_edge && timeout_cnt == TIMEOUT_LIMIT) begin
        frame_err   <= 1'b1;
        state       <= IDLE;
        shift_reg   <= 8'h00;
        bit_cnt     <= 3'd0;
        timeout_cnt <= 13'd0;
      end else begin
        if (state == IDLE || fall_edge) begin
          timeout_cnt <= 13'd0;
        end else begin
          timeout_cnt <= timeout_cnt + 13'd1;
        end

        if (fall_edge) begin
          case (state)
            // A high sample here is a glitch or a false start; stay put.
            IDLE: begin
              if (!ps2_data_s2) begin
                state   <= DATA;
                bit_cnt <= 3'd0;
              end
            end
            DATA: begin
              shift_reg <= {ps2_data_s2, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
              end
            end
            PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
              parity_bit <= ps2_data_s2;
`endif
              state <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (!ps2_data_s2) begin
                frame_err <= 1'b1;
              end
`ifdef PS2_RX_PARITY_CHECK_EN
              // Odd parity: data plus parity bit must hold an odd number of 1s.
              else if (!(^{shift_reg, parity_bit})) begin
                parity_err <= 1'b1;
              end
`endif
              else begin
                wr_data <= shift_reg;
                we      <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

`ifndef PS2_RX_PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver
// Directed bench for ps2_receiver: drives PS/2 frames bit by bit, watches the
// output strobes with a small monitor and compares counts, data and timing
// against hand-computed expectations.
`timescale 1ns/1ps

module tb_ps2_receiver;

  // PS/2 half period in wr_clk cycles, shortened from the real 12.5 kHz rate
  // to keep the run short; still far inside the 5000-cycle timeout.
  localparam int HALF = 40;

  // Frames are {stop, parity, data[7:0], start}, sent bit 0 first.
  localparam logic [10:0] FRAME_1C_GOOD    = {1'b1, 1'b0, 8'h1C, 1'b0};
  localparam logic [10:0] FRAME_F0_GOOD    = {1'b1, 1'b1, 8'hF0, 1'b0};
  localparam logic [10:0] FRAME_1C_BADPAR  = {1'b1, 1'b1, 8'h1C, 1'b0};
  localparam logic [10:0] FRAME_1C_BADSTOP = {1'b0, 1'b0, 8'h1C, 1'b0};
  localparam logic [10:0] FRAME_IDLE_HIGH  = 11'h7FF;

  logic       reset;
  logic       wr_clk;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] wr_data;
  logic       we;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;

  int we_count = 0;
  int ferr_count = 0;
  int perr_count = 0;
  int we_wide = 0;
  int ferr_wide = 0;
  int perr_wide = 0;
  int overlap = 0;
  int we_cycle = 0;
  int ferr_cycle = 0;
  logic [7:0] we_log [0:15];
  logic we_q = 1'b0;
  logic ferr_q = 1'b0;
  logic perr_q = 1'b0;

  int exp_we = 0;
  int exp_ferr = 0;
  int exp_perr = 0;
  logic [7:0] exp_data = 8'h00;

  ps2_receiver #(.TIMEOUT_CYCLES(5000)) dut (
    .reset      (reset),
    .wr_clk     (wr_clk),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .wr_data    (wr_data),
    .we         (we),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial wr_clk = 1'b0;
  always #10 wr_clk = ~wr_clk;

  always @(posedge wr_clk) cyc <= cyc + 1;

  // Monitor: counts rising edges of each strobe, logs written bytes and notes
  // any strobe that lasts more than one cycle or overlaps another.
  always @(negedge wr_clk) begin
    if (we) begin
      if (we_q) we_wide++;
      else begin
        if (we_count < 16) we_log[we_count] = wr_data;
        we_count++;
        we_cycle = cyc;
      end
    end
    if (frame_err) begin
      if (ferr_q) ferr_wide++;
      else begin
        ferr_count++;
        ferr_cycle = cyc;
      end
    end
    if (parity_err) begin
      if (perr_q) perr_wide++;
      else perr_count++;
    end
    if ((int'(we) + int'(frame_err) + int'(parity_err)) > 1) overlap++;
    we_q   = we;
    ferr_q = frame_err;
    perr_q = parity_err;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_we_count"}, we_count, exp_we);
    checkOutput({tag, "_ferr_count"}, ferr_count, exp_ferr);
    checkOutput({tag, "_perr_count"}, perr_count, exp_perr);
    checkOutput({tag, "_wr_data"}, {24'h0, wr_data}, {24'h0, exp_data});
    checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // Sends frame bits first_bit..last_bit: data changes while the clock is
  // high, then the clock falls for half a period and rises again.
  task automatic applyStimulus(input logic [10:0] frame, input int first_bit,
                               input int last_bit);
    for (int i = first_bit; i <= last_bit; i++) begin
      @(negedge wr_clk);
      ps2_data = frame[i];
      repeat (HALF) @(negedge wr_clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge wr_clk);
      ps2_clk = 1'b1;
    end
  endtask

  initial begin
    int waited;
    int delay;
    $display("[TB] start");
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge wr_clk);

    // Reset state.
    checkOutput("rst_wr_data", {24'h0, wr_data}, 32'h00);
    checkOutput("rst_we", {31'h0, we}, 32'h0);
    checkOutput("rst_frame_err", {31'h0, frame_err}, 32'h0);
    checkOutput("rst_parity_err", {31'h0, parity_err}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge wr_clk);

    // Single good 0x1C frame, with a busy check part way through.
    applyStimulus(FRAME_1C_GOOD, 0, 5);
    checkOutput("mid_frame_busy", {31'h0, busy}, 32'h1);
    applyStimulus(FRAME_1C_GOOD, 6, 10);
    exp_we++;
    exp_data = 8'h1C;
    checkCounters("frame_1c");
    checkOutput("we_latency", we_cycle - last_fall, 3);

    // Back-to-back 0xF0 then 0x1C with no idle gap.
    applyStimulus(FRAME_F0_GOOD, 0, 10);
    applyStimulus(FRAME_1C_GOOD, 0, 10);
    exp_we += 2;
    checkCounters("b2b");
    checkOutput("b2b_first_byte", {24'h0, we_log[1]}, 32'hF0);
    checkOutput("b2b_second_byte", {24'h0, we_log[2]}, 32'h1C);

    // False start: a clock fall with data high while idle is ignored.
    applyStimulus(FRAME_IDLE_HIGH, 0, 0);
    checkCounters("false_start");

    // Leave 0xF0 in wr_data so the following error frames can show it holds.
    applyStimulus(FRAME_F0_GOOD, 0, 10);
    exp_we++;
    exp_data = 8'hF0;
    checkCounters("preload_f0");

    // 0x1C with wrong parity.
    applyStimulus(FRAME_1C_BADPAR, 0, 10);
`ifdef PS2_RX_PARITY_CHECK_EN
    exp_perr++;
`else
    exp_we++;
    exp_data = 8'h1C;
`endif
    checkCounters("bad_parity");

    // 0x1C with stop bit 0.
    applyStimulus(FRAME_1C_BADSTOP, 0, 10);
    exp_ferr++;
    checkCounters("bad_stop");

    // Start plus 4 data bits, then the clock stays high.
    applyStimulus(FRAME_1C_GOOD, 0, 4);
    waited = 0;
    while (ferr_count == exp_ferr && waited < 6000) begin
      @(negedge wr_clk);
      waited++;
    end
    exp_ferr++;
    delay = ferr_cycle - last_fall;
    checkOutput("timeout_delay_window", {31'h0, (delay >= 5000 && delay <= 5010)}, 32'h1);
    while (cyc - last_fall < 6000) @(negedge wr_clk);
    checkCounters("timeout");
    applyStimulus(FRAME_F0_GOOD, 0, 10);
    exp_we++;
    exp_data = 8'hF0;
    checkCounters("after_timeout");

    // Reset after the 5th data bit of 0x1C aborts the frame silently.
    applyStimulus(FRAME_1C_GOOD, 0, 5);
    checkOutput("pre_reset_busy", {31'h0, busy}, 32'h1);
    @(negedge wr_clk);
    reset = 1'b1;
    repeat (3) @(negedge wr_clk);
    checkOutput("in_reset_wr_data", {24'h0, wr_data}, 32'h00);
    checkOutput("in_reset_we", {31'h0, we}, 32'h0);
    checkOutput("in_reset_frame_err", {31'h0, frame_err}, 32'h0);
    checkOutput("in_reset_parity_err", {31'h0, parity_err}, 32'h0);
    checkOutput("in_reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    exp_data = 8'h00;
    repeat (5) @(negedge wr_clk);
    checkCounters("aborted");
    applyStimulus(FRAME_F0_GOOD, 0, 10);
    exp_we++;
    exp_data = 8'hF0;
    checkCounters("after_reset");

    // Strobe shape over the whole run.
    checkOutput("we_single_cycle", we_wide, 0);
    checkOutput("ferr_single_cycle", ferr_wide, 0);
    checkOutput("perr_single_cycle", perr_wide, 0);
    checkOutput("strobe_exclusive", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
